// File: rtl/dogx_range_combiner_if.sv
// Sample bus of the range combiner: the multi-range sample strobe going in and
// the combined word (with its selection tag) coming out.
interface dogx_range_combiner_if #(
    parameter int N_RANGES = 3,
    parameter int IN_W     = 9,
    parameter int OUT_W    = 16
);
    logic                          valid_in;
    logic [N_RANGES*IN_W-1:0]      data_in;
    logic                          valid_out;
    logic signed [OUT_W-1:0]       data_out;
    logic [1:0]                    sel_out;
    logic                          range_changed;

    // Sample source side (upstream noise-shaper datapaths / test driver)
    modport master (
        output valid_in, data_in,
        input  valid_out, data_out, sel_out, range_changed
    );

    // Combiner side
    modport slave (
        input  valid_in, data_in,
        output valid_out, data_out, sel_out, range_changed
    );
endinterface

// File: rtl/dogx_range_combiner.sv
// Multi-range gain combiner. Picks one of N_RANGES signed samples per strobe
// using an up-step / hold-then-down-step policy (or a forced range), rescales
// the picked sample by that range's shift and emits one registered word.
// A selection decision made on one sample only affects the following sample.
module dogx_range_combiner #(
    parameter int N_RANGES = 3,
    parameter int IN_W     = 9,
    parameter int OUT_W    = 16
) (
    input  logic                    CLK_3M,
    input  logic                    reset,
    dogx_range_combiner_if.slave    bus,
    input  logic [N_RANGES*3-1:0]   gain_shift,
    input  logic [IN_W-1:0]         th_high,
    input  logic [IN_W-1:0]         th_low,
    input  logic [7:0]              hold_len,
    input  logic                    manual_en,
    input  logic [1:0]              manual_sel
);

    // Refuse to build configurations the datapath cannot represent.
    if ((N_RANGES < 2) || (N_RANGES > 4) || (OUT_W < IN_W + 7)) begin : g_bad_cfg
        $error("dogx_range_combiner: need 2 <= N_RANGES <= 4 and OUT_W >= IN_W+7");
    end

    localparam logic [1:0] TOP_SEL = 2'(N_RANGES - 1);

    typedef enum logic {
        MODE_AUTO   = 1'b0,
        MODE_MANUAL = 1'b1
    } mode_e;

    // Selection state and registered outputs
    logic [1:0]              sel_r;
    logic [7:0]              hold_r;
    logic                    valid_out_r;
    logic signed [OUT_W-1:0] data_out_r;
    logic [1:0]              sel_out_r;
    logic                    range_changed_r;

    // Combinational datapath / next-state
    logic signed [IN_W-1:0]  slice_s [4];
    logic [2:0]              shift_s [4];
    logic signed [IN_W-1:0]  x_s;
    logic [2:0]              x_shift_s;
    logic [IN_W-1:0]         mag_s;
    logic signed [OUT_W-1:0] scaled_s;
    logic [8:0]              hold_inc_s;
    logic [1:0]              man_sel_s;
    mode_e                   mode_s;
    logic [1:0]              sel_nxt_s;
    logic [7:0]              hold_nxt_s;

    // Unpack ranges into a fixed 4-entry table so a 2-bit index is always legal;
    // unused entries read as zero.
    for (genvar r = 0; r < 4; r++) begin : g_slice
        if (r < N_RANGES) begin : g_used
            assign slice_s[r] = bus.data_in[r*IN_W +: IN_W];
            assign shift_s[r] = gain_shift[r*3 +: 3];
        end else begin : g_unused
            assign slice_s[r] = {IN_W{1'b0}};
            assign shift_s[r] = 3'd0;
        end
    end

    // Pick the sample of the current (pre-update) range, its magnitude and its scaled value.
    always_comb begin
        x_s       = slice_s[sel_r];
        x_shift_s = shift_s[sel_r];
        mag_s     = x_s;
        if (x_s[IN_W-1]) begin
            // Two's-complement negate; the most negative code maps to 2^(IN_W-1) unsigned.
            mag_s = ~x_s + {{(IN_W-1){1'b0}}, 1'b1};
        end else begin
            mag_s = x_s;
        end
        scaled_s   = {{(OUT_W-IN_W){x_s[IN_W-1]}}, x_s} <<< x_shift_s;
        hold_inc_s = {1'b0, hold_r} + 9'd1;
    end

    // Mode decode and clamp of the forced range to the implemented ranges.
    always_comb begin
        mode_s    = MODE_AUTO;
        man_sel_s = manual_sel;
        if (manual_en) begin
            mode_s = MODE_MANUAL;
        end else begin
            mode_s = MODE_AUTO;
        end
        if (manual_sel > TOP_SEL) begin
            man_sel_s = TOP_SEL;
        end else begin
            man_sel_s = manual_sel;
        end
    end

    // Next selection / hold count: up-step wins, down-step only after hold_len quiet samples.
    always_comb begin
        sel_nxt_s  = sel_r;
        hold_nxt_s = hold_r;
        if (bus.valid_in) begin
            case (mode_s)
                MODE_MANUAL: begin
                    sel_nxt_s  = man_sel_s;
                    hold_nxt_s = 8'd0;
                end
                MODE_AUTO: begin
                    if (mag_s >= th_high) begin
                        hold_nxt_s = 8'd0;
                        if (sel_r < TOP_SEL) begin
                            sel_nxt_s = sel_r + 2'd1;
                        end else begin
                            sel_nxt_s = sel_r;
                        end
                    end else if (mag_s < th_low) begin
                        if ((hold_len != 8'd0) && (hold_inc_s == {1'b0, hold_len})) begin
                            // Quiet long enough: count restarts whether or not a lower range exists.
                            hold_nxt_s = 8'd0;
                            if (sel_r != 2'd0) begin
                                sel_nxt_s = sel_r - 2'd1;
                            end else begin
                                sel_nxt_s = sel_r;
                            end
                        end else if (hold_r == 8'd255) begin
                            hold_nxt_s = 8'd255;
                        end else begin
                            hold_nxt_s = hold_inc_s[7:0];
                        end
                    end else begin
                        hold_nxt_s = 8'd0;
                    end
                end
                default: begin
                    sel_nxt_s  = sel_r;
                    hold_nxt_s = hold_r;
                end
            endcase
        end else begin
            sel_nxt_s  = sel_r;
            hold_nxt_s = hold_r;
        end
    end

    // State and output registers; idle cycles hold everything except the strobes.
    always_ff @(posedge CLK_3M) begin
        if (!reset) begin
            sel_r           <= 2'd0;
            hold_r          <= 8'd0;
            valid_out_r     <= 1'b0;
            data_out_r      <= {OUT_W{1'b0}};
            sel_out_r       <= 2'd0;
            range_changed_r <= 1'b0;
        end else begin
            sel_r       <= sel_nxt_s;
            hold_r      <= hold_nxt_s;
            valid_out_r <= bus.valid_in;
            if (bus.valid_in) begin
                data_out_r      <= scaled_s;
                sel_out_r       <= sel_r;
                range_changed_r <= (sel_nxt_s != sel_r);
            end else begin
                range_changed_r <= 1'b0;
            end
        end
    end

    assign bus.valid_out     = valid_out_r;
    assign bus.data_out      = data_out_r;
    assign bus.sel_out       = sel_out_r;
    assign bus.range_changed = range_changed_r;

endmodule

// File: doc/dogx_range_combiner.md
# dogx_range_combiner

Parametrised successor to the two-channel HSNR/HDR alpha combiner. It takes N_RANGES synchronous signed samples, one per gain range, ordered from range 0 (most sensitive) to range N_RANGES-1 (coarsest). It selects one range per sample with a hysteresis/hold state machine, or uses a manually forced range. It then rescales the selected sample by a per-range runtime shift and emits one registered OUT_W-bit word. It sits between the per-channel noise-shaper datapaths and the downstream DC filter / fifth-order NS.

## Interface
- N_RANGES, 3: number of input ranges; legal range 2..4.
- IN_W, 9: width of each signed input sample.
- OUT_W, 16: output width; must satisfy OUT_W >= IN_W+7. Elaboration fails otherwise.
- CLK_3M  in  1  sole clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- valid_in  in  1  sample strobe; data_in is valid in this cycle.
- data_in  in  N_RANGES*IN_W  packed signed samples; range r occupies bits [r*IN_W +: IN_W].
- gain_shift  in  N_RANGES*3  per-range left shift, 0..7, applied to the selected sample.
- th_high  in  IN_W  unsigned up-step magnitude threshold.
- th_low  in  IN_W  unsigned down-step magnitude threshold.
- hold_len  in  8  number of consecutive quiet samples required before a down-step; 0 disables down-steps.
- manual_en  in  1  1 = forced selection, 0 = automatic selection.
- manual_sel  in  2  forced range index.
- valid_out  out  1  output-word strobe.
- data_out  out  OUT_W  signed combined sample.
- sel_out  out  2  range index used for the current data_out.
- range_changed  out  1  one-cycle pulse, coincident with valid_out, when the selection state changed on this sample.

## Operation
- State: sel_q (2 bits) and hold_cnt (8 bits). FSM modes are AUTO (manual_en=0) and MANUAL (manual_en=1). manual_en is sampled each valid cycle.
- Every step below happens only on cycles with valid_in=1. With valid_in=0, all state and data_out hold, and valid_out=0.
- Output path: x = data_in slice at index sel_q, where sel_q is the value before the update.
  - data_out <= sign_extend(x, OUT_W) <<< gain_shift[sel_q].
  - sel_out <= sel_q.
  - The sample is always processed with the old selection; a decision takes effect on the next sample.
- Magnitude: m = |x| as an IN_W-bit unsigned value. The most negative input, -2^(IN_W-1), gives m = 2^(IN_W-1); there is no overflow.
- AUTO mode, evaluated in priority order:
  1. m >= th_high and sel_q < N_RANGES-1: sel_q <= sel_q+1 and hold_cnt <= 0.
  2. m >= th_high at the top range: hold_cnt <= 0 and sel_q holds.
  3. m < th_low: hold_cnt <= hold_cnt+1, saturating at 255. If hold_len != 0, hold_cnt+1 == hold_len and sel_q > 0, then sel_q <= sel_q-1 and hold_cnt <= 0.
  4. Otherwise: hold_cnt <= 0.
  - The up-step always wins. If th_low > th_high, a sample satisfying both conditions steps up.
  - At range 0 with the hold condition met, hold_cnt clears and no step occurs.
- MANUAL mode:
  - sel_q <= min(manual_sel, N_RANGES-1) and hold_cnt <= 0.
  - On the return to AUTO, the search starts from the last forced range.
- range_changed <= (new sel_q != old sel_q).
- gain_shift, thresholds and hold_len may change at any time. They are used as sampled on each valid cycle.

## Timing
- Latency: valid_in at edge k produces valid_out, data_out, sel_out and range_changed at edge k+1. Throughput is one sample per cycle.
- A selection change decided on sample n applies to sample n+1, whichever cycle that sample arrives in.
- Reset (reset=0 at a rising edge) clears sel_q, hold_cnt, valid_out, data_out, sel_out and range_changed to 0. This applies mid-operation: a sample presented on the reset edge is dropped, with no valid_out after it.
- Back-to-back up-steps are allowed, one range per sample. Going from range 0 to the top range takes N_RANGES-1 samples.

## Test plan
All scenarios use N_RANGES=3, IN_W=9, OUT_W=16, gain_shift={r2:4, r1:2, r0:0}, th_high=200, th_low=40, hold_len=4.
- Reset then idle: after reset, all outputs are 0. With valid_in=0 for 10 cycles, valid_out stays 0 and data_out stays 0.
- Up-step: range 0 sample = -230.
  - Response: data_out=-230, sel_out=0, range_changed=1. On the next sample (range1=70), data_out=280 and sel_out=1.
- Down-step hold: at sel=1, feed range1 = 10,10,10,10.
  - Response: the 4th sample outputs sel_out=1 with range_changed=1, and the 5th sample uses range 0.
  - An intervening 50 restarts the count.
- Priority and saturation:
  - th_low=300, range0=-256 (m=256): steps up.
  - At sel=2 with range2=255: no step, range_changed=0, data_out=4080.
- Manual override: manual_en=1, manual_sel=3 clamps to range 2 (range_changed=1). Releasing to AUTO with a quiet input starts the down-count from 2.
- Mid-stream reset: reset=0 on a valid cycle with a pending hold_cnt=3. The next cycle has valid_out=0, sel_out=0, and hold_cnt restarts from 0.
